debug_word_sender: RTL and testbench

- Transmit-side counterpart of the debug unit's instruction loader: the loader assembles UART RX bytes into 32-bit words, and this block splits 32-bit MIPS state words into UART TX bytes.
- On a start pulse it walks a fixed dump sequence: PC, clock-wizard cycle count, register file R0..R(NUM_REGISTERS-1), then data memory words 0..NUM_MEM_WORDS-1.
- It drives the MIPS register/memory select addresses and sends each word MSB byte first through the UART TX start/done handshake.
- It sits between TOP_MIPS outputs and the UART transmitter, and is owned by the debug unit.

---
 rtl/debug_word_sender.sv | 147 ++++++++++++++
 tb/tb_debug_word_sender.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/debug_word_sender.sv
// debug_word_sender: dumps PC, cycle count, register file and data memory as MSB-first UART bytes.
// Define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte after the last word.
module debug_word_sender #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_TRAMA    = 8,
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_MEM_WORDS = 32
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic                             i_uart_tx_done,
  input  logic [BITS_SIZE-1:0]             i_mips_pc,
  input  logic [BITS_SIZE-1:0]             i_clk_wiz_count,
  input  logic [BITS_SIZE-1:0]             i_data_reg_file,
  input  logic [BITS_SIZE-1:0]             i_data_mem,
  output logic [$clog2(NUM_REGISTERS)-1:0] o_select_register_dir,
  output logic [BITS_SIZE-1:0]             o_select_mem_dir,
  output logic [SIZE_TRAMA-1:0]            o_uart_tx_data,
  output logic                             o_flag_tx_ready,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int BPW   = BITS_SIZE / SIZE_TRAMA;
  localparam int TOTAL = 2 + NUM_REGISTERS + NUM_MEM_WORDS;
  localparam int KW    = $clog2(TOTAL);
  localparam int RW    = $clog2(NUM_REGISTERS);
  localparam int CW    = $clog2(BPW) + 1;

  typedef enum logic [2:0] {
    IDLE, SELECT, LATCH, SEND, WAIT_DONE, NEXT, FINISH
`ifdef DEBUG_TX_CHECKSUM_EN
    , CHKSUM
`endif
  } state_t;

  state_t               state;
  logic [KW-1:0]        k;
  logic [CW-1:0]        cnt;
  logic [BITS_SIZE-1:0] shift, src, sh_nx, mem_nx;
  logic [RW-1:0]        reg_nx;
  int                   kn;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [SIZE_TRAMA-1:0] chk;
`endif

  // Select addresses are computed for the next word so they are registered on entry to SELECT.
  always_comb begin
    kn     = int'(k) + 1;
    sh_nx  = shift << SIZE_TRAMA;
    reg_nx = (kn >= 2 && kn < 2 + NUM_REGISTERS) ? RW'(kn - 2) : '0;
    mem_nx = (kn >= 2 + NUM_REGISTERS) ? BITS_SIZE'((kn - 2 - NUM_REGISTERS) * 4) : '0;
    src    = (int'(k) == 0) ? i_mips_pc :
             (int'(k) == 1) ? i_clk_wiz_count :
             (int'(k) < 2 + NUM_REGISTERS) ? i_data_reg_file : i_data_mem;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state                 <= IDLE;
      k                     <= '0;
      cnt                   <= '0;
      shift                 <= '0;
      o_select_register_dir <= '0;
      o_select_mem_dir      <= '0;
      o_uart_tx_data        <= '0;
      o_flag_tx_ready       <= 1'b0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
      chk                   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state                 <= SELECT;
          o_busy                <= 1'b1;
          k                     <= '0;
          o_select_register_dir <= '0;
          o_select_mem_dir      <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
          chk                   <= '0;
`endif
        end
        SELECT: state <= LATCH;
        LATCH: begin
          shift           <= src;
          cnt             <= '0;
          o_uart_tx_data  <= src[BITS_SIZE-1 -: SIZE_TRAMA];
          o_flag_tx_ready <= 1'b1;
          state           <= SEND;
        end
        SEND: begin
          o_flag_tx_ready <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
          chk             <= chk ^ o_uart_tx_data;
`endif
          state           <= WAIT_DONE;
        end
        WAIT_DONE: if (i_uart_tx_done) begin
          shift <= sh_nx;
          cnt   <= cnt + 1'b1;
          if (int'(cnt) + 1 == BPW) state <= NEXT;
          else begin
            o_uart_tx_data  <= sh_nx[BITS_SIZE-1 -: SIZE_TRAMA];
            o_flag_tx_ready <= 1'b1;
            state           <= SEND;
          end
        end
        NEXT: if (int'(k) == TOTAL - 1) begin
          o_select_register_dir <= '0;
          o_select_mem_dir      <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
          o_uart_tx_data        <= chk;
          o_flag_tx_ready       <= 1'b1;
          state                 <= CHKSUM;
`else
          o_done                <= 1'b1;
          o_busy                <= 1'b0;
          state                 <= FINISH;
`endif
        end else begin
          k                     <= k + 1'b1;
          o_select_register_dir <= reg_nx;
          o_select_mem_dir      <= mem_nx;
          state                 <= SELECT;
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        // A done coincident with the start pulse belongs to no byte of ours.
        CHKSUM: begin
          o_flag_tx_ready <= 1'b0;
          if (i_uart_tx_done && !o_flag_tx_ready) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= FINISH;
          end
        end
`endif
        FINISH: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_word_sender.sv
// tb_debug_word_sender: scoreboard bench for debug_word_sender with a UART done-pulse model.
module tb_debug_word_sender;
  localparam int NR = 32, NM = 32, TOTAL = 2 + NR + NM;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int NB = TOTAL * 4 + 1;
`else
  localparam int NB = TOTAL * 4;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, uart_done = 1'b0, spur_done = 1'b0, tx_done;
  logic [31:0] pc = '0, cyc = '0, reg_data, mem_data, sel_mem;
  logic [4:0]  sel_reg;
  logic [7:0]  tx_data;
  logic        tx_ready, busy, done;

  typedef struct {
    logic [7:0]  b;
    logic [4:0]  r;
    logic [31:0] m;
  } exp_t;

  exp_t       q[$];
  logic [7:0] rx[$];
  int n_cmp = 0, n_bad = 0, dup = 0, done_cnt = 0, base = 0, stall_at = -1, spur_at = -1;

  always #5 clk = ~clk;

  assign tx_done  = uart_done | spur_done;
  assign reg_data = 32'h100 + 32'(sel_reg);
  assign mem_data = 32'hDEAD0000 + sel_mem;

  debug_word_sender dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_uart_tx_done(tx_done),
    .i_mips_pc(pc), .i_clk_wiz_count(cyc), .i_data_reg_file(reg_data), .i_data_mem(mem_data),
    .o_select_register_dir(sel_reg), .o_select_mem_dir(sel_mem), .o_uart_tx_data(tx_data),
    .o_flag_tx_ready(tx_ready), .o_busy(busy), .o_done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_dump(input logic [31:0] p, input logic [31:0] c);
    logic [31:0] w;
    exp_t e;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0] x = '0;
`endif
    for (int k = 0; k < TOTAL; k++) begin
      w = k == 0 ? p : k == 1 ? c : k < 2 + NR ? 32'h100 + 32'(k - 2) : 32'hDEAD0000 + 32'((k - 2 - NR) * 4);
      e.r = (k >= 2 && k < 2 + NR) ? 5'(k - 2) : '0;
      e.m = k >= 2 + NR ? 32'((k - 2 - NR) * 4) : '0;
      for (int b = 0; b < 4; b++) begin
        e.b = w[31 - 8 * b -: 8];
`ifdef DEBUG_TX_CHECKSUM_EN
        x ^= e.b;
`endif
        q.push_back(e);
      end
    end
`ifdef DEBUG_TX_CHECKSUM_EN
    e.b = x;
    e.r = '0;
    e.m = '0;
    q.push_back(e);
`endif
  endtask

  task automatic start_dump(input logic [31:0] p, input logic [31:0] c);
    int lat;
    pc   = p;
    cyc  = c;
    base = rx.size();
    push_dump(p, c);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 1;
    while (!tx_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
  endtask

  task automatic finish_dump();
    int c = 0;
    while (!done && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("byte_count", 32'(rx.size() - base), 32'(NB));
    check("queue_drained", 32'(q.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  // UART model: answers each start pulse with a done pulse 10 cycles later (or a long stall).
  initial begin
    int   wc = 0;
    int   idx;
    exp_t e;
    forever begin
      @(negedge clk);
      uart_done = 1'b0;
      if (done) done_cnt++;
      if (wc > 0) begin
        wc--;
        if (wc == 0) uart_done = 1'b1;
      end
      if (tx_ready) begin
        idx = rx.size() - base;
        if (wc > 0) dup++;
        check("byte_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("byte", 32'(tx_data), 32'(e.b));
          check("sel_reg", 32'(sel_reg), 32'(e.r));
          check("sel_mem", sel_mem, e.m);
        end
        rx.push_back(tx_data);
        wc = idx == stall_at ? 1000 : 10;
        if (idx == spur_at) uart_done = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] ord[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'hA5};
    int c, d0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_sel_reg", 32'(sel_reg), 32'd0);
    check("rst_sel_mem", sel_mem, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_dump(32'h12345678, 32'h000000A5);
    finish_dump();
    for (int i = 0; i < 8; i++) check("byte_order", 32'(rx[base + i]), 32'(ord[i]));

    repeat (3) begin
      @(negedge clk) spur_done = 1'b1;
      @(negedge clk) spur_done = 1'b0;
    end
    check("idle_spurious_busy", 32'(busy), 32'd0);
    stall_at = 20;
    spur_at  = 5;
    start_dump(32'hCAFEF00D, 32'h0BADBEEF);
    repeat (3) begin
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    finish_dump();
    stall_at = -1;
    spur_at  = -1;

    start_dump(32'h12345678, 32'h000000A5);
    c = 0;
    while (rx.size() - base < 37 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("reached_byte_37", 32'(rx.size() - base), 32'd37);
    rst_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_ready", 32'(tx_ready), 32'd0);
    check("abort_sel_mem", sel_mem, 32'd0);
    q.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_idle", 32'(busy), 32'd0);

    start_dump(32'h12345678, 32'h000000A5);
    check("restart_pc_byte", 32'(tx_data), 32'h12);
    finish_dump();

    check("dup_tx_pulses", 32'(dup), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
